// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream: Hamming(7,4) stream encoder with 2-entry output FIFO and single-bit error injection
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake, in_data = {d3,d2,d1,d0}
//   inj_en/inj_pos        flip code[inj_pos-1] of the accepted word (inj_pos 0 = no flip)
//   out_valid/out_ready   output handshake, out_code = {p1,p2,d3,p4,d2,d1,d0}
//   out_injected          head codeword carries an injected error
//   cw_count              wrapping count of handed-off codewords
module hamming_encoder_stream #(
  parameter int CNT_W = 16,
  parameter bit INJ_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic             out_injected,
  output logic [CNT_W-1:0] cw_count
);
  logic [7:0] mem [2];
  logic [1:0] count;
  logic       wp, rp, live, push, pop, inj;
  logic [6:0] enc, flip;
  always_comb begin
    enc = {in_data[3] ^ in_data[2] ^ in_data[0], in_data[3] ^ in_data[1] ^ in_data[0], in_data[3],
           in_data[2] ^ in_data[1] ^ in_data[0], in_data[2:0]};
    inj = INJ_ENABLE && inj_en && inj_pos != 3'd0;
    flip = inj ? 7'd1 << (inj_pos - 3'd1) : 7'd0;
  end
  // live keeps in_ready low until the first edge after reset release
  assign in_ready     = live && count != 2'd2;
  assign out_valid    = count != 2'd0;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign out_code     = mem[rp][6:0];
  assign out_injected = mem[rp][7];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      count    <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      live     <= 1'b0;
      cw_count <= '0;
    end else begin
      live  <= 1'b1;
      count <= count + 2'(push) - 2'(pop);
      if (push) begin
        mem[wp] <= {inj, enc ^ flip};
        wp      <= ~wp;
      end
      if (pop) begin
        rp       <= ~rp;
        cw_count <= cw_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb_hamming_encoder_stream: scoreboard bench for hamming_encoder_stream (injecting and non-injecting instances)
module tb_hamming_encoder_stream;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, inj_en = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic [2:0] inj_pos = '0;
  logic in_ready, out_valid, out_injected, in_ready0, out_valid0, out_injected0;
  logic [6:0] out_code, out_code0;
  logic [3:0] cw_count, cw_count0;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q[$], q0[$];
  logic [6:0] tbl [16] = '{7'h00, 7'h69, 7'h2A, 7'h43, 7'h4C, 7'h25, 7'h66, 7'h0F,
                           7'h70, 7'h19, 7'h5A, 7'h33, 7'h3C, 7'h55, 7'h16, 7'h7F};

  hamming_encoder_stream #(.CNT_W(4), .INJ_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_injected(out_injected), .cw_count(cw_count));

  hamming_encoder_stream #(.CNT_W(4), .INJ_ENABLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid0), .out_ready(out_ready),
    .out_code(out_code0), .out_injected(out_injected0), .cw_count(cw_count0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("code", {out_injected, out_code}, q.pop_front());
    end

  always @(negedge clk)
    if (rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("unexpected_out0", 1, 0);
      else chk("code_noinj", {out_injected0, out_code0}, q0.pop_front());
    end

  task automatic send(input logic [3:0] d, input logic ie, input logic [2:0] p,
                      input logic [6:0] c, input logic [6:0] c0, input logic fi);
    int n = 0;
    in_valid = 1'b1; in_data = d; inj_en = ie; inj_pos = p;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      q.push_back({fi, c});
      q0.push_back({1'b0, c0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_injected", out_injected, 0);
    chk("rst_cw_count", cw_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(4'hB, 1'b0, 3'd0, 7'h33, 7'h33, 1'b0);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_code", out_code, 7'h33);
    @(posedge clk); #1;
    chk("cw_count_1", cw_count, 1);
    chk("drained_valid", out_valid, 0);
    c = cyc;
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0, 3'd0, tbl[i], tbl[i], 1'b0);
    chk("throughput", cyc - c, 16);
    @(posedge clk); #1;
    chk("cw_count_17", cw_count, 1);
    send(4'hF, 1'b1, 3'd3, 7'h7B, 7'h7F, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h5, 1'b0, 3'd0, 7'h25, 7'h25, 1'b0);
    send(4'hA, 1'b0, 3'd7, 7'h5A, 7'h5A, 1'b0);
    in_valid = 1'b1; in_data = 4'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_code", out_code, 7'h25);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'hC, 1'b0, 3'd0, 7'h3C, 7'h3C, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);
    send(4'h1, 1'b0, 3'd0, 7'h69, 7'h69, 1'b0);
    send(4'h6, 1'b1, 3'd7, 7'h26, 7'h66, 1'b1);
    send(4'h9, 1'b1, 3'd0, 7'h19, 7'h19, 1'b0);
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h2, 1'b0, 3'd0, 7'h2A, 7'h2A, 1'b0);
    send(4'h4, 1'b0, 3'd0, 7'h4C, 7'h4C, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_code", out_code, 0);
    q.delete();
    q0.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_cw_count", cw_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(4'(i), 1'b0, 3'd0, tbl[i], tbl[i], 1'b0);
    @(posedge clk); #1;
    chk("cw_count_15", cw_count, 15);
    send(4'hF, 1'b0, 3'd0, 7'h7F, 7'h7F, 1'b0);
    @(posedge clk); #1;
    chk("cw_count_wrap", cw_count, 0);
    chk("queue_left", q.size(), 0);
    chk("queue0_left", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
